// File: rtl/rename_pkg.sv
// Shared sizing defaults and the RAT entry type for the rename unit.
package rename_pkg;

  localparam int AREGS_DEF = 32;
  localparam int PREGS_DEF = 64;
  localparam int AW_DEF    = 5;
  localparam int PW_DEF    = 6;

  typedef logic [PW_DEF-1:0] rat_entry_t;

endpackage

// File: rtl/rename_unit_if.sv
// Rename-stage bus: decode input, free-list pop, commit port and the renamed output.
interface rename_unit_if #(
  parameter int AW = rename_pkg::AW_DEF,
  parameter int PW = rename_pkg::PW_DEF
);

  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic          in_rd_we;
  logic          in_ready;
  logic          free_deque;
  logic [PW-1:0] free_data;
  logic          free_empty;
  logic          commit_valid;
  logic [AW-1:0] commit_areg;
  logic [PW-1:0] commit_preg;
  logic          out_valid;
  logic [PW-1:0] out_ps;
  logic [PW-1:0] out_pt;
  logic [PW-1:0] out_pd;
  logic [PW-1:0] out_old_pd;
  logic          out_rd_we;

  modport slave (
    input  stall, flush, in_valid, in_rs, in_rt, in_rd, in_rd_we,
    input  free_data, free_empty, commit_valid, commit_areg, commit_preg,
    output in_ready, free_deque,
    output out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we
  );

  modport master (
    output stall, flush, in_valid, in_rs, in_rt, in_rd, in_rd_we,
    output free_data, free_empty, commit_valid, commit_areg, commit_preg,
    input  in_ready, free_deque,
    input  out_valid, out_ps, out_pt, out_pd, out_old_pd, out_rd_we
  );

endinterface

// File: rtl/rename_rat.sv
// Register alias table: identity map on reset, two combinational read ports,
// one write port and a whole-table load that takes priority over the write.
module rename_rat #(
  parameter int AREGS = rename_pkg::AREGS_DEF,
  parameter int PW    = rename_pkg::PW_DEF,
  parameter int AW    = rename_pkg::AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra0_i,
  input  logic [AW-1:0] ra1_i,
  output logic [PW-1:0] rd0_o,
  output logic [PW-1:0] rd1_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [PW-1:0] wd_i,
  input  logic          load_i,
  input  logic [PW-1:0] load_data_i [AREGS],
  output logic [PW-1:0] tbl_o [AREGS]
);

  logic [PW-1:0] tbl_q [AREGS];

  generate
    for (genvar gi = 0; gi < AREGS; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tbl_q[gi] <= PW'(gi);
        end else if (load_i) begin
          tbl_q[gi] <= load_data_i[gi];
        end else if (we_i && (wa_i == AW'(gi))) begin
          tbl_q[gi] <= wd_i;
        end
      end
      assign tbl_o[gi] = tbl_q[gi];
    end
  endgenerate

  assign rd0_o = tbl_q[ra0_i];
  assign rd1_o = tbl_q[ra1_i];

endmodule

// File: rtl/rename_unit.sv
// Register rename stage with speculative and retirement RATs and flush recovery.
// Optional RENAME_ZERO_REG_EN pins arch r0 to physical 0 (no pop, commits ignored).
module rename_unit
  import rename_pkg::*;
#(
  parameter int AREGS = AREGS_DEF,
  parameter int PREGS = PREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int PW    = PW_DEF
) (
  input logic           clk,
  input logic           reset,
  rename_unit_if.slave  bus
);

  generate
    if (AREGS > PREGS || PREGS > (1 << PW) || AREGS > (1 << AW)) begin : g_bad_cfg
      $error("rename_unit: inconsistent AREGS/PREGS/AW/PW");
    end
  endgenerate

  logic          eff_we;
  logic          commit_we;
  logic          in_ready;
  logic          accept;
  logic          spec_we;
  logic [PW-1:0] spec_ps;
  logic [PW-1:0] spec_pt;
  logic [PW-1:0] unused_ret_rd0;
  logic [PW-1:0] unused_ret_rd1;
  logic [PW-1:0] spec_tbl  [AREGS];
  logic [PW-1:0] ret_tbl   [AREGS];
  logic [PW-1:0] flush_tbl [AREGS];

  logic          out_valid_q;
  logic [PW-1:0] out_ps_q;
  logic [PW-1:0] out_pt_q;
  logic [PW-1:0] out_pd_q;
  logic [PW-1:0] out_old_pd_q;
  logic          out_rd_we_q;

`ifdef RENAME_ZERO_REG_EN
  assign eff_we    = bus.in_rd_we & (bus.in_rd != '0);
  assign commit_we = bus.commit_valid & (bus.commit_areg != '0);
`else
  assign eff_we    = bus.in_rd_we;
  assign commit_we = bus.commit_valid;
`endif

  assign in_ready       = ~bus.stall & ~bus.flush & (~bus.in_rd_we | ~bus.free_empty);
  assign accept         = bus.in_valid & in_ready;
  assign spec_we        = accept & eff_we;
  assign bus.in_ready   = in_ready;
  assign bus.free_deque = spec_we;

  // Flush recovery must see a commit retiring in the same cycle.
  generate
    for (genvar gi = 0; gi < AREGS; gi++) begin : g_flush
      assign flush_tbl[gi] = (commit_we && (bus.commit_areg == AW'(gi))) ?
                             bus.commit_preg : ret_tbl[gi];
    end
  endgenerate

  rename_rat #(.AREGS(AREGS), .PW(PW), .AW(AW)) u_spec_rat (
    .clk         (clk),
    .reset       (reset),
    .ra0_i       (bus.in_rs),
    .ra1_i       (bus.in_rt),
    .rd0_o       (spec_ps),
    .rd1_o       (spec_pt),
    .we_i        (spec_we),
    .wa_i        (bus.in_rd),
    .wd_i        (bus.free_data),
    .load_i      (bus.flush),
    .load_data_i (flush_tbl),
    .tbl_o       (spec_tbl)
  );

  rename_rat #(.AREGS(AREGS), .PW(PW), .AW(AW)) u_ret_rat (
    .clk         (clk),
    .reset       (reset),
    .ra0_i       (bus.commit_areg),
    .ra1_i       (bus.in_rd),
    .rd0_o       (unused_ret_rd0),
    .rd1_o       (unused_ret_rd1),
    .we_i        (commit_we),
    .wa_i        (bus.commit_areg),
    .wd_i        (bus.commit_preg),
    .load_i      (1'b0),
    .load_data_i (spec_tbl),
    .tbl_o       (ret_tbl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_ps_q     <= '0;
      out_pt_q     <= '0;
      out_pd_q     <= '0;
      out_old_pd_q <= '0;
      out_rd_we_q  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      if (accept) begin
        out_valid_q  <= 1'b1;
        out_ps_q     <= spec_ps;
        out_pt_q     <= spec_pt;
        out_pd_q     <= eff_we ? bus.free_data : '0;
        out_old_pd_q <= eff_we ? spec_tbl[bus.in_rd] : '0;
        out_rd_we_q  <= eff_we;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_ps     = out_ps_q;
  assign bus.out_pt     = out_pt_q;
  assign bus.out_pd     = out_pd_q;
  assign bus.out_old_pd = out_old_pd_q;
  assign bus.out_rd_we  = out_rd_we_q;

endmodule
